// File: rtl/lif_dp.sv
// Datapath for one fully-connected LIF layer: neuron counters, per-output membranes,
// saturating weighted accumulate with leak, fire decision and output spike vector.
module lif_dp #(
    parameter int                        N_IN       = 16,
    parameter int                        N_OUT      = 8,
    parameter int                        W_WIDTH    = 8,
    parameter int                        V_WIDTH    = 16,
    parameter logic signed [V_WIDTH-1:0] THRESH     = 16'sd256,
    parameter int                        LEAK_SHIFT = 4,
    parameter logic signed [V_WIDTH-1:0] V_RESET    = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               mem_clr,
    input  logic                               clr_all,
    input  logic                               acc_init,
    input  logic                               acc_step,
    input  logic                               wr1,
    input  logic                               wr0,
    input  logic                               next_out,
    input  logic [N_IN-1:0]                    in_spikes,
    output logic [$clog2(N_IN*N_OUT)-1:0]      w_addr,
    input  logic signed [W_WIDTH-1:0]          w_data,
    output logic                               ini_last,
    output logic                               out_last,
    output logic                               fired,
    output logic [N_OUT-1:0]                   out_spikes,
    output logic                               out_valid
);

    localparam int IN_W   = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int OUT_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int ADDR_W = $clog2(N_IN*N_OUT);

    localparam logic signed [V_WIDTH-1:0] V_MAX = {1'b0, {(V_WIDTH-1){1'b1}}};
    localparam logic signed [V_WIDTH-1:0] V_MIN = {1'b1, {(V_WIDTH-1){1'b0}}};

    logic [IN_W-1:0]            in_idx_q,  in_idx_d;
    logic [OUT_W-1:0]           out_idx_q, out_idx_d;
    logic signed [V_WIDTH-1:0]  acc_q,     acc_d;
    logic signed [V_WIDTH-1:0]  v_mem_q [N_OUT];
    logic signed [V_WIDTH-1:0]  v_mem_d [N_OUT];
    logic [N_OUT-1:0]           out_spikes_q, out_spikes_d;
    logic                       out_valid_q,  out_valid_d;

    logic do_mem_clr, do_clr_all, do_acc_init, do_acc_step;
    logic do_wr1, do_wr0, do_next_out;

    logic signed [V_WIDTH-1:0]  v_cur;
    logic signed [V_WIDTH-1:0]  v_leaked;
    logic signed [V_WIDTH:0]    acc_ext;
    logic signed [V_WIDTH:0]    w_ext;
    logic signed [V_WIDTH:0]    sum_wide;
    logic signed [V_WIDTH-1:0]  acc_sat;
    logic                       spike_sel;

    // Commands are nominally one-hot; collapse any overlap to the highest priority one.
    always_comb begin
        do_mem_clr  = mem_clr;
        do_clr_all  = !mem_clr && clr_all;
        do_acc_init = !mem_clr && !clr_all && acc_init;
        do_acc_step = !mem_clr && !clr_all && !acc_init && acc_step;
        do_wr1      = !mem_clr && !clr_all && !acc_init && !acc_step && wr1;
        do_wr0      = !mem_clr && !clr_all && !acc_init && !acc_step && !wr1 && wr0;
        do_next_out = !mem_clr && !clr_all && !acc_init && !acc_step && !wr1 && !wr0
                      && next_out;
    end

    assign ini_last  = (in_idx_q  == IN_W'(N_IN - 1));
    assign out_last  = (out_idx_q == OUT_W'(N_OUT - 1));
    assign w_addr    = ADDR_W'(out_idx_q) * ADDR_W'(N_IN) + ADDR_W'(in_idx_q);
    assign spike_sel = in_spikes[in_idx_q];
    assign fired     = (acc_q >= THRESH);

    assign v_cur = v_mem_q[out_idx_q];

    generate
        if (LEAK_SHIFT == 0) begin : g_no_leak
            assign v_leaked = v_cur;
        end else begin : g_leak
            assign v_leaked = v_cur - (v_cur >>> LEAK_SHIFT);
        end
    endgenerate

    // One guard bit is enough to detect overflow of a single signed add.
    assign acc_ext  = {acc_q[V_WIDTH-1], acc_q};
    assign w_ext    = {{(V_WIDTH+1-W_WIDTH){w_data[W_WIDTH-1]}}, w_data};
    assign sum_wide = acc_ext + w_ext;

    always_comb begin
        acc_sat = sum_wide[V_WIDTH-1:0];
        if (sum_wide[V_WIDTH] != sum_wide[V_WIDTH-1]) begin
            acc_sat = sum_wide[V_WIDTH] ? V_MIN : V_MAX;
        end
    end

    always_comb begin
        in_idx_d  = in_idx_q;
        out_idx_d = out_idx_q;
        if (do_clr_all) begin
            in_idx_d  = '0;
            out_idx_d = '0;
        end else if (do_acc_init) begin
            in_idx_d = '0;
        end else if (do_acc_step) begin
            in_idx_d = ini_last ? '0 : in_idx_q + IN_W'(1);
        end else if (do_next_out) begin
            out_idx_d = out_last ? '0 : out_idx_q + OUT_W'(1);
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (do_acc_init) begin
            acc_d = v_leaked;
        end else if (do_acc_step && spike_sel) begin
            acc_d = acc_sat;
        end
    end

    // Membranes are only touched by mem_clr and the write-back commands, so they persist across passes.
    always_comb begin
        v_mem_d = v_mem_q;
        if (do_mem_clr) begin
            for (int i = 0; i < N_OUT; i++) begin
                v_mem_d[i] = '0;
            end
        end else if (do_wr1) begin
            v_mem_d[out_idx_q] = V_RESET;
        end else if (do_wr0) begin
            v_mem_d[out_idx_q] = acc_q;
        end
    end

    always_comb begin
        out_spikes_d = out_spikes_q;
        out_valid_d  = out_valid_q;
        if (do_clr_all) begin
            out_spikes_d = '0;
            out_valid_d  = 1'b0;
        end else if (do_wr1) begin
            out_spikes_d[out_idx_q] = 1'b1;
        end else if (do_wr0) begin
            out_spikes_d[out_idx_q] = 1'b0;
        end else if (do_next_out && out_last) begin
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_idx_q     <= '0;
            out_idx_q    <= '0;
            acc_q        <= '0;
            out_spikes_q <= '0;
            out_valid_q  <= 1'b0;
            for (int i = 0; i < N_OUT; i++) begin
                v_mem_q[i] <= '0;
            end
        end else begin
            in_idx_q     <= in_idx_d;
            out_idx_q    <= out_idx_d;
            acc_q        <= acc_d;
            out_spikes_q <= out_spikes_d;
            out_valid_q  <= out_valid_d;
            for (int i = 0; i < N_OUT; i++) begin
                v_mem_q[i] <= v_mem_d[i];
            end
        end
    end

    assign out_spikes = out_spikes_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_lif_dp.sv
// Bench for lif_dp: a small 4x2 layer for the main checks plus an 8-bit-membrane
// instance that exercises accumulator saturation.
module tb_lif_dp;

    localparam logic [6:0] C_MEMCLR = 7'b1000000;
    localparam logic [6:0] C_CLR    = 7'b0100000;
    localparam logic [6:0] C_INIT   = 7'b0010000;
    localparam logic [6:0] C_STEP   = 7'b0001000;
    localparam logic [6:0] C_WR1    = 7'b0000100;
    localparam logic [6:0] C_WR0    = 7'b0000010;
    localparam logic [6:0] C_NEXT   = 7'b0000001;

    logic              clk = 1'b0;
    logic              rst;
    logic [6:0]        cmd;
    logic              mem_clr, clr_all, acc_init, acc_step, wr1, wr0, next_out;
    logic [3:0]        in_spikes;
    logic [2:0]        w_addr;
    logic signed [7:0] w_data;
    logic              ini_last, out_last, fired, out_valid;
    logic [1:0]        out_spikes;
    logic signed [7:0] wmem [8];

    logic [3:0]        in_spikes_s;
    logic [2:0]        w_addr_s;
    logic signed [7:0] sat_w;
    logic              ini_last_s, out_last_s, fired_s, out_valid_s;
    logic [1:0]        out_spikes_s;

    int compared   = 0;
    int mismatched = 0;

    assign {mem_clr, clr_all, acc_init, acc_step, wr1, wr0, next_out} = cmd;
    assign w_data      = wmem[w_addr];
    assign in_spikes_s = 4'b1111;

    always #5 clk = ~clk;

    lif_dp #(
        .N_IN(4), .N_OUT(2), .W_WIDTH(8), .V_WIDTH(16),
        .THRESH(16'sd256), .LEAK_SHIFT(4), .V_RESET(16'sd0)
    ) dut (
        .clk(clk), .rst(rst), .mem_clr(mem_clr), .clr_all(clr_all),
        .acc_init(acc_init), .acc_step(acc_step), .wr1(wr1), .wr0(wr0),
        .next_out(next_out), .in_spikes(in_spikes), .w_addr(w_addr),
        .w_data(w_data), .ini_last(ini_last), .out_last(out_last),
        .fired(fired), .out_spikes(out_spikes), .out_valid(out_valid)
    );

    lif_dp #(
        .N_IN(4), .N_OUT(2), .W_WIDTH(8), .V_WIDTH(8),
        .THRESH(8'sd127), .LEAK_SHIFT(4), .V_RESET(8'sd0)
    ) dut_s (
        .clk(clk), .rst(rst), .mem_clr(mem_clr), .clr_all(clr_all),
        .acc_init(acc_init), .acc_step(acc_step), .wr1(wr1), .wr0(wr0),
        .next_out(next_out), .in_spikes(in_spikes_s), .w_addr(w_addr_s),
        .w_data(sat_w), .ini_last(ini_last_s), .out_last(out_last_s),
        .fired(fired_s), .out_spikes(out_spikes_s), .out_valid(out_valid_s)
    );

    typedef struct {
        logic [6:0] cmd;
        int         exp_addr;
        logic       exp_ini;
        logic       exp_olast;
        int         exp_acc;
        logic       exp_fired;
        logic [1:0] exp_spk;
        logic       exp_valid;
    } vec_t;

    vec_t vecs [15];

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pulse(input logic [6:0] c);
        cmd = c;
        @(posedge clk);
        #1;
        cmd = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_weights(input logic signed [7:0] w);
        for (int i = 0; i < 8; i++) wmem[i] = w;
    endtask

    // Combinational outputs are checked before the edge, registered state after it.
    task automatic applyStimulus(input vec_t v, input int row);
        cmd = v.cmd;
        #1;
        checkOutput($sformatf("row%0d w_addr", row),   int'(w_addr),   v.exp_addr);
        checkOutput($sformatf("row%0d ini_last", row), int'(ini_last), int'(v.exp_ini));
        checkOutput($sformatf("row%0d out_last", row), int'(out_last), int'(v.exp_olast));
        @(posedge clk);
        #1;
        cmd = '0;
        checkOutput($sformatf("row%0d acc", row),        int'(dut.acc_q),    v.exp_acc);
        checkOutput($sformatf("row%0d fired", row),      int'(fired),        int'(v.exp_fired));
        checkOutput($sformatf("row%0d out_spikes", row), int'(out_spikes),   int'(v.exp_spk));
        checkOutput($sformatf("row%0d out_valid", row),  int'(out_valid),    int'(v.exp_valid));
    endtask

    task automatic run_table(input string tag);
        for (int r = 0; r < 15; r++) applyStimulus(vecs[r], r);
        checkOutput({tag, " wrap w_addr"},   int'(w_addr),   0);
        checkOutput({tag, " wrap out_last"}, int'(out_last), 0);
        checkOutput({tag, " v_mem0"},        int'(dut.v_mem_q[0]), 0);
        checkOutput({tag, " v_mem1"},        int'(dut.v_mem_q[1]), 0);
    endtask

    task automatic run_neuron(input int exp_init, input int exp_final, input logic exp_fire,
                              input string tag);
        pulse(C_INIT);
        checkOutput({tag, " acc_init"}, int'(dut.acc_q), exp_init);
        repeat (4) pulse(C_STEP);
        checkOutput({tag, " acc_final"}, int'(dut.acc_q), exp_final);
        checkOutput({tag, " fired"},     int'(fired),     int'(exp_fire));
        pulse(exp_fire ? C_WR1 : C_WR0);
        pulse(C_NEXT);
    endtask

    initial begin
        vecs[0]  = '{C_CLR,  0, 1'b0, 1'b0,   0, 1'b0, 2'b00, 1'b0};
        vecs[1]  = '{C_INIT, 0, 1'b0, 1'b0,   0, 1'b0, 2'b00, 1'b0};
        vecs[2]  = '{C_STEP, 0, 1'b0, 1'b0, 100, 1'b0, 2'b00, 1'b0};
        vecs[3]  = '{C_STEP, 1, 1'b0, 1'b0, 200, 1'b0, 2'b00, 1'b0};
        vecs[4]  = '{C_STEP, 2, 1'b0, 1'b0, 200, 1'b0, 2'b00, 1'b0};
        vecs[5]  = '{C_STEP, 3, 1'b1, 1'b0, 300, 1'b1, 2'b00, 1'b0};
        vecs[6]  = '{C_WR1,  0, 1'b0, 1'b0, 300, 1'b1, 2'b01, 1'b0};
        vecs[7]  = '{C_NEXT, 0, 1'b0, 1'b0, 300, 1'b1, 2'b01, 1'b0};
        vecs[8]  = '{C_INIT, 4, 1'b0, 1'b1,   0, 1'b0, 2'b01, 1'b0};
        vecs[9]  = '{C_STEP, 4, 1'b0, 1'b1, 100, 1'b0, 2'b01, 1'b0};
        vecs[10] = '{C_STEP, 5, 1'b0, 1'b1, 200, 1'b0, 2'b01, 1'b0};
        vecs[11] = '{C_STEP, 6, 1'b0, 1'b1, 200, 1'b0, 2'b01, 1'b0};
        vecs[12] = '{C_STEP, 7, 1'b1, 1'b1, 300, 1'b1, 2'b01, 1'b0};
        vecs[13] = '{C_WR1,  4, 1'b0, 1'b1, 300, 1'b1, 2'b11, 1'b0};
        vecs[14] = '{C_NEXT, 4, 1'b0, 1'b1, 300, 1'b1, 2'b11, 1'b1};

        rst       = 1'b1;
        cmd       = '0;
        in_spikes = 4'b1011;
        sat_w     = 8'sd0;
        set_weights(8'sd100);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("reset acc",        int'(dut.acc_q),    0);
        checkOutput("reset w_addr",     int'(w_addr),       0);
        checkOutput("reset out_spikes", int'(out_spikes),   0);
        checkOutput("reset out_valid",  int'(out_valid),    0);
        checkOutput("reset fired",      int'(fired),        0);
        checkOutput("reset ini_last",   int'(ini_last),     0);
        checkOutput("reset out_last",   int'(out_last),     0);

        run_table("pass1");

        // Sub-threshold carry-over across three timesteps.
        do_reset();
        set_weights(8'sd50);
        in_spikes = 4'b0011;
        pulse(C_CLR);
        run_neuron(0, 100, 1'b0, "t1n0");
        run_neuron(0, 100, 1'b0, "t1n1");
        checkOutput("t1 v_mem0",     int'(dut.v_mem_q[0]), 100);
        checkOutput("t1 v_mem1",     int'(dut.v_mem_q[1]), 100);
        checkOutput("t1 out_spikes", int'(out_spikes), 0);
        checkOutput("t1 out_valid",  int'(out_valid),  1);
        pulse(C_CLR);
        checkOutput("t2 clr out_valid", int'(out_valid), 0);
        run_neuron(94, 194, 1'b0, "t2n0");
        run_neuron(94, 194, 1'b0, "t2n1");
        checkOutput("t2 v_mem1", int'(dut.v_mem_q[1]), 194);
        pulse(C_CLR);
        run_neuron(182, 282, 1'b1, "t3n0");
        run_neuron(182, 282, 1'b1, "t3n1");
        checkOutput("t3 out_spikes", int'(out_spikes), 3);
        checkOutput("t3 out_valid",  int'(out_valid),  1);
        checkOutput("t3 v_mem0",     int'(dut.v_mem_q[0]), 0);

        // Negative membrane: leak floors toward -inf.
        pulse(C_MEMCLR);
        set_weights(-8'sd50);
        pulse(C_CLR);
        run_neuron(0, -100, 1'b0, "negn0");
        pulse(C_CLR);
        pulse(C_INIT);
        checkOutput("neg leak acc", int'(dut.acc_q), -93);

        // Saturation on the 8-bit instance.
        do_reset();
        pulse(C_CLR);
        sat_w = 8'sd127;
        pulse(C_INIT);
        checkOutput("sat+ init", int'(dut_s.acc_q), 0);
        for (int k = 0; k < 4; k++) begin
            pulse(C_STEP);
            checkOutput($sformatf("sat+ step%0d acc", k), int'(dut_s.acc_q), 127);
        end
        checkOutput("sat+ fired", int'(fired_s), 1);
        sat_w = -8'sd128;
        pulse(C_INIT);
        checkOutput("sat- init", int'(dut_s.acc_q), 0);
        for (int k = 0; k < 4; k++) begin
            pulse(C_STEP);
            checkOutput($sformatf("sat- step%0d acc", k), int'(dut_s.acc_q), -128);
        end
        checkOutput("sat- fired", int'(fired_s), 0);

        // Priority and clear behaviour.
        do_reset();
        set_weights(8'sd100);
        in_spikes = 4'b1011;
        pulse(C_CLR);
        pulse(C_INIT);
        pulse(C_STEP);
        pulse(C_STEP);
        checkOutput("prio pre acc", int'(dut.acc_q), 200);
        pulse(C_INIT | C_STEP);
        checkOutput("prio init acc",    int'(dut.acc_q), 0);
        checkOutput("prio init w_addr", int'(w_addr),    0);
        checkOutput("prio init ini_last", int'(ini_last), 0);
        repeat (4) pulse(C_STEP);
        checkOutput("prio n0 acc", int'(dut.acc_q), 300);
        pulse(C_WR0);
        checkOutput("wr0 v_mem0",     int'(dut.v_mem_q[0]), 300);
        checkOutput("wr0 out_spikes", int'(out_spikes), 0);
        pulse(C_NEXT);
        pulse(C_INIT);
        checkOutput("n1 init acc", int'(dut.acc_q), 0);
        repeat (4) pulse(C_STEP);
        pulse(C_WR1 | C_WR0 | C_NEXT);
        checkOutput("wr1 prio out_spikes", int'(out_spikes), 2);
        checkOutput("wr1 prio w_addr",     int'(w_addr),     4);
        checkOutput("wr1 prio out_valid",  int'(out_valid),  0);
        pulse(C_NEXT);
        checkOutput("next out_valid", int'(out_valid), 1);
        checkOutput("next w_addr",    int'(w_addr),    0);
        pulse(C_MEMCLR | C_CLR | C_INIT);
        checkOutput("memclr v_mem0",     int'(dut.v_mem_q[0]), 0);
        checkOutput("memclr out_spikes", int'(out_spikes), 2);
        checkOutput("memclr out_valid",  int'(out_valid),  1);
        pulse(C_CLR);
        checkOutput("clr out_spikes", int'(out_spikes), 0);
        checkOutput("clr out_valid",  int'(out_valid),  0);

        // Reset in the middle of accumulation, then a clean pass.
        do_reset();
        pulse(C_CLR);
        pulse(C_INIT);
        repeat (4) pulse(C_STEP);
        pulse(C_WR1);
        pulse(C_NEXT);
        pulse(C_INIT);
        repeat (4) pulse(C_STEP);
        pulse(C_WR0);
        checkOutput("mid v_mem1", int'(dut.v_mem_q[1]), 300);
        pulse(C_INIT);
        checkOutput("mid leak acc", int'(dut.acc_q), 282);
        pulse(C_STEP);
        pulse(C_STEP);
        checkOutput("mid acc", int'(dut.acc_q), 482);
        rst = 1'b1;
        cmd = C_STEP;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cmd = '0;
        checkOutput("midrst acc",        int'(dut.acc_q),      0);
        checkOutput("midrst v_mem0",     int'(dut.v_mem_q[0]), 0);
        checkOutput("midrst v_mem1",     int'(dut.v_mem_q[1]), 0);
        checkOutput("midrst out_spikes", int'(out_spikes),     0);
        checkOutput("midrst out_valid",  int'(out_valid),      0);
        checkOutput("midrst w_addr",     int'(w_addr),         0);
        checkOutput("midrst fired",      int'(fired),          0);
        run_table("pass2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lif_dp.md
Name: lif_dp

Overview:
Datapath slave of the layer controller FSM for one fully-connected LIF layer. It holds the input/output neuron counters and the per-output membrane potentials, and runs the weighted accumulate with leak. It makes the fire decision and collects the output spike vector. It returns ini_last, out_last and fired to the controller and consumes its one-cycle command pulses.

Parameters:
- N_IN, 16, number of input neurons (>=2)
- N_OUT, 8, number of output neurons (>=2)
- W_WIDTH, 8, signed weight width
- V_WIDTH, 16, signed membrane/accumulator width
- THRESH, 16'sd256, signed firing threshold (V_WIDTH bits)
- LEAK_SHIFT, 4, leak = v>>>LEAK_SHIFT; 0 disables leak
- V_RESET, 0, membrane value written on fire

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- mem_clr  in  1  clear all membranes (new inference)
- clr_all  in  1  controller: layer-pass init
- acc_init  in  1  controller: load leaked membrane into accumulator
- acc_step  in  1  controller: one input-neuron accumulate step
- wr1  in  1  controller: write fired result
- wr0  in  1  controller: write not-fired result
- next_out  in  1  controller: advance output neuron
- in_spikes  in  N_IN  input spike vector, stable for the whole pass
- w_addr  out  clog2(N_IN*N_OUT)  weight address = out_idx*N_IN + in_idx (combinational)
- w_data  in  W_WIDTH  signed weight, asynchronous read, valid in the same cycle as w_addr
- ini_last  out  1  in_idx == N_IN-1 (combinational)
- out_last  out  1  out_idx == N_OUT-1 (combinational)
- fired  out  1  acc >= THRESH, signed compare (combinational)
- out_spikes  out  N_OUT  registered output spike vector
- out_valid  out  1  out_spikes complete for this pass

Behaviour:
- Command priority: rst > mem_clr > clr_all > acc_init > acc_step > wr1 > wr0 > next_out. The controller drives one-hot commands; if several are high together, only the highest-priority one acts.
- rst: in_idx, out_idx, acc, all v_mem, out_spikes and out_valid are set to 0.
- mem_clr: all v_mem set to 0. Counters and outputs are unchanged.
- clr_all: in_idx<=0, out_idx<=0, out_spikes<=0, out_valid<=0. v_mem is untouched, so membranes persist across timesteps.
- acc_init: in_idx<=0, acc <= v - (v>>>LEAK_SHIFT), where v = v_mem[out_idx]. The shift is arithmetic and floors toward -inf. With LEAK_SHIFT=0, acc<=v.
- acc_step:
  - If in_spikes[in_idx]=1: acc <= sat(acc + sext(w_data)), computed in V_WIDTH+1 bits and saturated to [-2^(V_WIDTH-1), 2^(V_WIDTH-1)-1].
  - If in_spikes[in_idx]=0: acc holds.
  - in_idx increments; it wraps to 0 after N_IN-1.
  - ini_last is high during the final step cycle. The controller leaves its accumulate state on that same edge.
- fired is valid in the cycle after the last acc_step and is sampled by the controller in its decide state.
- wr1: v_mem[out_idx]<=V_RESET, out_spikes[out_idx]<=1.
- wr0: v_mem[out_idx]<=acc, out_spikes[out_idx]<=0.
- next_out:
  - out_idx increments and wraps to 0 after N_OUT-1.
  - If out_last was high in that cycle, out_valid<=1; it stays high until the next clr_all or rst.
- Latency per pass: 1 + N_OUT*(N_IN+4) controller cycles; out_valid rises in the cycle before the controller's done pulse.
- Saturation never wraps. acc at max plus a positive weight stays at max; acc at min plus a negative weight stays at min.
- A step on an unspiked input still advances in_idx and still drives w_addr; the weight is ignored.
- rst mid-pass returns everything to reset values. The controller restarts from idle, and a partial accumulation is never written.
- in_spikes changing mid-pass is a protocol violation; results are undefined but no X or lockup is allowed.

Test Plan:
1. Reset, then full pass: N_IN=4, N_OUT=2, LEAK_SHIFT=4, THRESH=256, in_spikes=4'b1011, all weights +100 -> neuron0 acc=300, fired=1, out_spikes[0]=1, v_mem[0]=0; same for neuron1; out_valid=1 after the final next_out; w_addr sequence 0,1,2,3,4,5,6,7.
2. Sub-threshold carry-over: weights +50, in_spikes=4'b0011. Pass 1: v_mem=100, no fire. Pass 2: acc_init gives 100-6=94, then 94+100=194, no fire. Pass 3: 194-12=182, then 282, fires and out_spikes=2'b11.
3. Saturation: weights +127, V_WIDTH=8, THRESH=127 -> acc clamps at 127 (never wraps negative) and fired=1. With weights -128, acc clamps at -128.
4. Counter boundaries: ini_last high only at in_idx=3; out_last only at out_idx=1; in_idx wraps to 0 after the 4th step; out_idx wraps to 0 after the 2nd next_out.
5. Priority and clear: acc_init and acc_step asserted together -> only acc_init acts. mem_clr mid-run zeros all v_mem while out_spikes holds. clr_all zeros out_spikes and out_valid.
6. rst asserted during the accumulate phase -> next cycle all outputs are 0 and v_mem is 0; a following full pass matches scenario 1 exactly.
